// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter and sequencer in front of the single
//   shared 32-bit ALU. One operation is in flight at a time. The flow is:
//     IDLE : the winning request is accepted and its operands are registered
//            onto ALU_A/ALU_B/ALU_INST.
//     EXEC : the combinational ALU settles. Its result and flags are captured
//            into the owner's response registers.
//     RESP : the owner's response is held until it is consumed.
//   A request handshake at clock edge T gives a response that is valid after
//   edge T+1. READY is visible during the cycle before edge T, so VALID rises
//   two cycles after READY. Each operation takes at least 3 cycles.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   REQn_VALID/READY      request handshake for requester n (n = 0, 1)
//   REQn_A/B/INST         operands and ALU instruction for requester n
//   RSPn_VALID/READY      response handshake for requester n
//   RSPn_Z/FLAGS          result and flags {reserved, Zero, CarryOut, Overflow}
//   ALU_A/B/INST          registered operands driven into the ALU
//   ALU_Z/FLAGS           combinational ALU result and flags
//
// Optional build macro:
//   ALU_ARBITER_STATS_EN  adds two 16-bit outputs that saturate at 16'hFFFF:
//                         OP_COUNT  counts completed response handshakes.
//                         OVF_COUNT counts completed responses with FLAGS[0]=1.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W  = 32,
    parameter int IW = 4,
    parameter int FW = 4
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          REQ0_VALID,
    output logic          REQ0_READY,
    input  logic [W-1:0]  REQ0_A,
    input  logic [W-1:0]  REQ0_B,
    input  logic [IW-1:0] REQ0_INST,

    input  logic          REQ1_VALID,
    output logic          REQ1_READY,
    input  logic [W-1:0]  REQ1_A,
    input  logic [W-1:0]  REQ1_B,
    input  logic [IW-1:0] REQ1_INST,

    output logic          RSP0_VALID,
    input  logic          RSP0_READY,
    output logic [W-1:0]  RSP0_Z,
    output logic [FW-1:0] RSP0_FLAGS,

    output logic          RSP1_VALID,
    input  logic          RSP1_READY,
    output logic [W-1:0]  RSP1_Z,
    output logic [FW-1:0] RSP1_FLAGS,

    output logic [W-1:0]  ALU_A,
    output logic [W-1:0]  ALU_B,
    output logic [IW-1:0] ALU_INST,
    input  logic [W-1:0]  ALU_Z,
    input  logic [FW-1:0] ALU_FLAGS
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]   OP_COUNT,
    output logic [15:0]   OVF_COUNT
`endif
);

    // At reset, ALU_INST holds the "constant zero" opcode, so the idle ALU
    // produces a quiet, known output.
    localparam logic [IW-1:0] INST_ZERO = IW'(4'b1110);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic owner;       // requester that owns the in-flight operation
    logic last_grant;  // most recently granted requester
    logic grant0;
    logic grant1;
    logic accept;      // a request handshake completes this cycle
    logic rsp_hs;      // the owner's response handshake completes this cycle

    // -------------------------------------------------------------------------
    // Round-robin grant. One valid requester always wins. When both are valid,
    // the requester that was not granted last wins.
    // -------------------------------------------------------------------------
    assign grant0 = REQ0_VALID & (~REQ1_VALID | last_grant);
    assign grant1 = REQ1_VALID & (~REQ0_VALID | ~last_grant);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: Use non-blocking (<=) for every flop. All registers then sample
    // the pre-edge values, which removes ordering races between always_ff
    // blocks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: Every signal this block drives gets a default before the case
    // statement. A missed assignment on any path would otherwise infer a
    // latch.
    always_comb begin
        state_next = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        accept     = 1'b0;
        rsp_hs     = 1'b0;

        case (state)
            IDLE: begin
                // While RST is high the state is already IDLE. Qualifying
                // READY with RST keeps every READY low during reset, even
                // when a requester is holding VALID.
                REQ0_READY = grant0 & ~RST;
                REQ1_READY = grant1 & ~RST;
                accept     = REQ0_READY | REQ1_READY;
                if (accept) begin
                    state_next = EXEC;
                end
            end

            EXEC: begin
                state_next = RESP;
            end

            RESP: begin
                RSP0_VALID = ~owner;
                RSP1_VALID = owner;
                // The non-owner's RSP_READY is ignored.
                rsp_hs     = owner ? RSP1_READY : RSP0_READY;
                if (rsp_hs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand registers, owner and round-robin pointer.
    // These registers load only on an accepted request. In every other cycle
    // they hold their value, so the ALU inputs do not toggle while unused.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_INST   <= INST_ZERO;
            owner      <= 1'b0;
            last_grant <= 1'b1;  // requester 0 wins the first contest
        end else if (accept) begin
            ALU_A      <= REQ1_READY ? REQ1_A    : REQ0_A;
            ALU_B      <= REQ1_READY ? REQ1_B    : REQ0_B;
            ALU_INST   <= REQ1_READY ? REQ1_INST : REQ0_INST;
            owner      <= REQ1_READY;
            last_grant <= REQ1_READY;
        end
    end

    // -------------------------------------------------------------------------
    // Response data registers.
    // In EXEC, the ALU result is captured into the owner's registers only.
    // The other requester's last result is left unchanged. The data is not
    // cleared after the response handshake; only VALID drops.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RSP0_Z     <= '0;
            RSP0_FLAGS <= '0;
            RSP1_Z     <= '0;
            RSP1_FLAGS <= '0;
        end else if (state == EXEC) begin
            if (owner) begin
                RSP1_Z     <= ALU_Z;
                RSP1_FLAGS <= ALU_FLAGS;
            end else begin
                RSP0_Z     <= ALU_Z;
                RSP0_FLAGS <= ALU_FLAGS;
            end
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters. They saturate instead of wrapping, so a long run
    // never reports a small, misleading count.
    // -------------------------------------------------------------------------
    logic rsp_ovf;
    assign rsp_ovf = owner ? RSP1_FLAGS[0] : RSP0_FLAGS[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OP_COUNT  <= '0;
            OVF_COUNT <= '0;
        end else if (rsp_hs) begin
            if (OP_COUNT != 16'hFFFF) begin
                OP_COUNT <= OP_COUNT + 16'd1;
            end
            if (rsp_ovf && (OVF_COUNT != 16'hFFFF)) begin
                OVF_COUNT <= OVF_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter. A small behavioural ALU stands in for
//   the real functional unit. Single operations are driven from a table of
//   vectors with hand-computed results. The following cases are written out
//   as explicit sequences:
//     - round-robin fairness,
//     - response backpressure,
//     - reset during EXEC.
//   Outputs are sampled 1 ns after a falling edge. Inputs change on falling
//   edges.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int IW = 4;
    localparam int FW = 4;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_UNSP = 4'b0110;
    localparam logic [3:0] OP_ZERO = 4'b1110;

    logic          CLK;
    logic          RST;
    logic          REQ0_VALID, REQ0_READY;
    logic [W-1:0]  REQ0_A, REQ0_B;
    logic [IW-1:0] REQ0_INST;
    logic          REQ1_VALID, REQ1_READY;
    logic [W-1:0]  REQ1_A, REQ1_B;
    logic [IW-1:0] REQ1_INST;
    logic          RSP0_VALID, RSP0_READY;
    logic [W-1:0]  RSP0_Z;
    logic [FW-1:0] RSP0_FLAGS;
    logic          RSP1_VALID, RSP1_READY;
    logic [W-1:0]  RSP1_Z;
    logic [FW-1:0] RSP1_FLAGS;
    logic [W-1:0]  ALU_A, ALU_B, ALU_Z;
    logic [IW-1:0] ALU_INST;
    logic [FW-1:0] ALU_FLAGS;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]   OP_COUNT, OVF_COUNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.W(W), .IW(IW), .FW(FW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_A     (REQ0_A),
        .REQ0_B     (REQ0_B),
        .REQ0_INST  (REQ0_INST),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_A     (REQ1_A),
        .REQ1_B     (REQ1_B),
        .REQ1_INST  (REQ1_INST),
        .RSP0_VALID (RSP0_VALID),
        .RSP0_READY (RSP0_READY),
        .RSP0_Z     (RSP0_Z),
        .RSP0_FLAGS (RSP0_FLAGS),
        .RSP1_VALID (RSP1_VALID),
        .RSP1_READY (RSP1_READY),
        .RSP1_Z     (RSP1_Z),
        .RSP1_FLAGS (RSP1_FLAGS),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_INST   (ALU_INST),
        .ALU_Z      (ALU_Z),
        .ALU_FLAGS  (ALU_FLAGS)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .OP_COUNT   (OP_COUNT),
        .OVF_COUNT  (OVF_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // -------------------------------------------------------------------------
    // Behavioural ALU. FLAGS = {reserved, Zero, CarryOut, Overflow}.
    // Any unsupported opcode returns A ^ B.
    // -------------------------------------------------------------------------
    logic [W:0] alu_sum;
    logic       alu_ovf;
    always_comb begin
        alu_sum = '0;
        alu_ovf = 1'b0;
        case (ALU_INST)
            OP_ADD: begin
                alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
                alu_ovf = (ALU_A[W-1] == ALU_B[W-1]) && (alu_sum[W-1] != ALU_A[W-1]);
            end
            OP_SUB: begin
                alu_sum = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 33'd1;
                alu_ovf = (ALU_A[W-1] != ALU_B[W-1]) && (alu_sum[W-1] != ALU_A[W-1]);
            end
            OP_NEG: begin
                alu_sum = {1'b0, ~ALU_A} + 33'd1;
                alu_ovf = ALU_A[W-1] && alu_sum[W-1];
            end
            OP_ZERO: alu_sum = '0;
            default: alu_sum = {1'b0, ALU_A ^ ALU_B};
        endcase
        ALU_Z     = alu_sum[W-1:0];
        ALU_FLAGS = {1'b0, (alu_sum[W-1:0] == '0), alu_sum[W], alu_ovf};
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit r, input logic v, input logic [3:0] inst,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (r) begin
            REQ1_VALID = v; REQ1_INST = inst; REQ1_A = a; REQ1_B = b;
        end else begin
            REQ0_VALID = v; REQ0_INST = inst; REQ0_A = a; REQ0_B = b;
        end
    endtask

    function automatic logic ready_of(input bit r);
        return r ? REQ1_READY : REQ0_READY;
    endfunction

    function automatic logic valid_of(input bit r);
        return r ? RSP1_VALID : RSP0_VALID;
    endfunction

    function automatic logic [W-1:0] z_of(input bit r);
        return r ? RSP1_Z : RSP0_Z;
    endfunction

    function automatic logic [FW-1:0] flags_of(input bit r);
        return r ? RSP1_FLAGS : RSP0_FLAGS;
    endfunction

    typedef struct {
        string      name;
        bit         req;
        logic [3:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [3:0] flags;
    } vec_t;

    // Runs one uncontended operation and checks every phase of it.
    task automatic do_op(input vec_t v);
        int waited;
        @(negedge CLK);
        set_req(v.req, 1'b1, v.inst, v.a, v.b);
        RSP0_READY = 1'b1;
        RSP1_READY = 1'b1;
        waited = 0;
        #1;
        while (!ready_of(v.req) && waited < 20) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check({v.name, "/req_ready"}, ready_of(v.req), 1'b1);
        check({v.name, "/other_ready"}, ready_of(!v.req), 1'b0);
        // EXEC
        @(negedge CLK);
        set_req(v.req, 1'b0, v.inst, v.a, v.b);
        #1;
        check({v.name, "/exec_valid"}, valid_of(v.req), 1'b0);
        check({v.name, "/alu_a"}, ALU_A, v.a);
        check({v.name, "/alu_b"}, ALU_B, v.b);
        check({v.name, "/alu_inst"}, ALU_INST, v.inst);
        // RESP
        @(negedge CLK);
        #1;
        check({v.name, "/rsp_valid"}, valid_of(v.req), 1'b1);
        check({v.name, "/other_valid"}, valid_of(!v.req), 1'b0);
        check({v.name, "/z"}, z_of(v.req), v.z);
        check({v.name, "/flags"}, flags_of(v.req), v.flags);
        // Back in IDLE: VALID drops, the result data and ALU operands hold.
        @(negedge CLK);
        #1;
        check({v.name, "/valid_clear"}, valid_of(v.req), 1'b0);
        check({v.name, "/z_held"}, z_of(v.req), v.z);
        check({v.name, "/alu_a_held"}, ALU_A, v.a);
    endtask

    // Backstop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    vec_t vecs[4];
    vec_t neg_vec;

    initial begin
        bit   grants[$];
        int   dual_ready;
        int   long_pulse;
        bit   prev_ready;

        vecs[0] = '{"add_5_7",   1'b0, OP_ADD,  32'd5,         32'd7,         32'd12,        4'b0000};
        vecs[1] = '{"sub_3_3",   1'b1, OP_SUB,  32'd3,         32'd3,         32'd0,         4'b0110};
        vecs[2] = '{"add_ovf",   1'b0, OP_ADD,  32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b0001};
        vecs[3] = '{"unsup_op",  1'b1, OP_UNSP, 32'h0000F0F0,  32'h00000FF0,  32'h0000FF00,  4'b0000};
        neg_vec = '{"neg_after_rst", 1'b1, OP_NEG, 32'd1, 32'd0, 32'hFFFFFFFF, 4'b0000};

        RST = 1'b1;
        set_req(1'b0, 1'b0, 4'h0, '0, '0);
        set_req(1'b1, 1'b0, 4'h0, '0, '0);
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b0;

        // ---- Reset state ----
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst/req0_ready", REQ0_READY, 1'b0);
        check("rst/req1_ready", REQ1_READY, 1'b0);
        check("rst/rsp0_valid", RSP0_VALID, 1'b0);
        check("rst/rsp1_valid", RSP1_VALID, 1'b0);
        check("rst/alu_a", ALU_A, 32'd0);
        check("rst/alu_b", ALU_B, 32'd0);
        check("rst/alu_inst", ALU_INST, OP_ZERO);
        check("rst/rsp0_z", RSP0_Z, 32'd0);
        check("rst/rsp1_flags", RSP1_FLAGS, 4'd0);
        RST = 1'b0;

        // ---- Table-driven single operations ----
        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i]);
        end
`ifdef ALU_ARBITER_STATS_EN
        check("stats/op_count_table", OP_COUNT, 16'd4);
        check("stats/ovf_count_table", OVF_COUNT, 16'd1);
`endif

        // ---- Fairness: both requesters valid, responses consumed at once ----
        // The last table grant went to requester 1, so the order must be 0,1,0,1.
        @(negedge CLK);
        set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        set_req(1'b1, 1'b1, OP_ADD, 32'd2, 32'd2);
        RSP0_READY = 1'b1;
        RSP1_READY = 1'b1;
        dual_ready = 0;
        long_pulse = 0;
        prev_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
            #1;
            if (REQ0_READY && REQ1_READY) dual_ready++;
            if (REQ0_READY || REQ1_READY) begin
                if (prev_ready) long_pulse++;
                grants.push_back(REQ1_READY);
                prev_ready = 1'b1;
            end else begin
                prev_ready = 1'b0;
            end
            @(negedge CLK);
        end
        set_req(1'b0, 1'b0, OP_ADD, 32'd1, 32'd1);
        set_req(1'b1, 1'b0, OP_ADD, 32'd2, 32'd2);
        check("rr/grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            check($sformatf("rr/grant%0d", i), grants[i], i % 2);
        end
        check("rr/dual_ready", dual_ready, 0);
        check("rr/long_ready_pulse", long_pulse, 0);
        repeat (3) @(negedge CLK);

        // ---- Backpressure on RSP0 while requester 1 waits ----
        set_req(1'b0, 1'b1, OP_ADD, 32'd10, 32'd20);
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b1;
        #1;
        check("bp/req0_ready", REQ0_READY, 1'b1);
        @(negedge CLK);  // EXEC
        set_req(1'b0, 1'b0, OP_ADD, 32'd10, 32'd20);
        set_req(1'b1, 1'b1, OP_SUB, 32'd9, 32'd4);
        #1;
        check("bp/req1_ready_exec", REQ1_READY, 1'b0);
        for (int i = 0; i < 6; i++) begin  // RESP, then five stalled cycles
            @(negedge CLK);
            #1;
            check($sformatf("bp/rsp0_valid%0d", i), RSP0_VALID, 1'b1);
            check($sformatf("bp/rsp0_z%0d", i), RSP0_Z, 32'd30);
            check($sformatf("bp/rsp0_flags%0d", i), RSP0_FLAGS, 4'b0000);
            check($sformatf("bp/req1_ready%0d", i), REQ1_READY, 1'b0);
        end
        RSP0_READY = 1'b1;
        #1;
        check("bp/req1_ready_during_hs", REQ1_READY, 1'b0);
        @(negedge CLK);
        #1;
        check("bp/req1_granted", REQ1_READY, 1'b1);
        check("bp/rsp0_valid_clear", RSP0_VALID, 1'b0);
        @(negedge CLK);  // EXEC for requester 1
        set_req(1'b1, 1'b0, OP_SUB, 32'd9, 32'd4);
        @(negedge CLK);
        #1;
        check("bp/rsp1_z", RSP1_Z, 32'd5);
        check("bp/rsp1_flags", RSP1_FLAGS, 4'b0010);
        @(negedge CLK);

        // ---- Reset asserted during EXEC ----
        set_req(1'b0, 1'b1, OP_ADD, 32'd100, 32'd200);
        RSP0_READY = 1'b0;
        #1;
        check("rx/req0_ready", REQ0_READY, 1'b1);
        @(negedge CLK);  // EXEC
        set_req(1'b0, 1'b0, OP_ADD, 32'd100, 32'd200);
        set_req(1'b1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("rx/req0_ready", REQ0_READY, 1'b0);
        check("rx/req1_ready", REQ1_READY, 1'b0);
        check("rx/rsp0_valid", RSP0_VALID, 1'b0);
        check("rx/alu_a", ALU_A, 32'd0);
        check("rx/alu_b", ALU_B, 32'd0);
        check("rx/alu_inst", ALU_INST, OP_ZERO);
        check("rx/rsp0_z", RSP0_Z, 32'd0);
        check("rx/rsp1_z", RSP1_Z, 32'd0);
        check("rx/rsp1_flags", RSP1_FLAGS, 4'd0);
`ifdef ALU_ARBITER_STATS_EN
        check("rx/op_count", OP_COUNT, 16'd0);
        check("rx/ovf_count", OVF_COUNT, 16'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        set_req(1'b1, 1'b0, OP_ADD, 32'd1, 32'd1);
        RSP0_READY = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            #1;
            check("rx/no_replay", RSP0_VALID, 1'b0);
        end
        // After reset the pointer favours requester 0 again.
        set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        set_req(1'b1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1;
        check("rx/first_grant0", REQ0_READY, 1'b1);
        check("rx/first_grant1", REQ1_READY, 1'b0);
        set_req(1'b0, 1'b0, OP_ADD, 32'd1, 32'd1);
        set_req(1'b1, 1'b0, OP_ADD, 32'd1, 32'd1);
        do_op(neg_vec);
`ifdef ALU_ARBITER_STATS_EN
        check("stats/op_count_end", OP_COUNT, 16'd1);
        check("stats/ovf_count_end", OVF_COUNT, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
